// File: rtl/div_unit_pkg.sv
// Shared ALU definitions: divide op encodings (low bits of RV32M funct3 1xx)
// and divider FSM state encodings.
package div_unit_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } div_state_e;

   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] CALC_LAST = 5'd31;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_unit_adder.sv
// Ripple-carry adder shared by the ALU datapaths.
module adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic carry;

   always_comb begin
      carry = cin;
      sum   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/div_unit.sv
// Fixed-latency (34 cycle) restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes at start; signs are reapplied in FIX.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy,
   output logic            o_done
);

   div_state_e       state;
   div_op_e          op_q;
   div_op_e          op_in;
   logic             neg_quo;
   logic             neg_rem;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem;
   logic [XLEN-1:0]  quo;
   logic [XLEN-1:0]  dvs;

   logic             a_neg;
   logic             b_neg;
   logic [XLEN-1:0]  a_mag;
   logic [XLEN-1:0]  b_mag;
   logic [XLEN-1:0]  rem_sh;
   logic [XLEN-1:0]  diff;
   logic [XLEN-1:0]  res_sel;
   logic             carry;
   logic             no_borrow;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + XLEN'(1)) : v;
   endfunction

   assign op_in = div_op_e'(i_op);
   assign a_neg = op_is_signed(op_in) & i_a[XLEN-1];
   assign b_neg = op_is_signed(op_in) & i_b[XLEN-1];
   assign a_mag = cond_neg(i_a, a_neg);
   assign b_mag = cond_neg(i_b, b_neg);

   // The quotient register doubles as the dividend shift register.
   assign rem_sh = {rem[XLEN-2:0], quo[XLEN-1]};

   adder #(.WIDTH(XLEN)) u_adder (
      .a    (rem_sh),
      .b    (~dvs),
      .cin  (1'b1),
      .sum  (diff),
      .cout (carry)
   );

   // The bit shifted out of rem is the 33rd bit of the partial remainder.
   assign no_borrow = carry | rem[XLEN-1];
   assign res_sel   = op_is_rem(op_q) ? cond_neg(rem, neg_rem) : cond_neg(quo, neg_quo);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= S_IDLE;
         op_q     <= OP_DIV;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         o_result <= '0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  op_q    <= op_in;
                  quo     <= a_mag;
                  dvs     <= b_mag;
                  // Divide by zero keeps an all-ones quotient unsigned.
                  neg_quo <= (a_neg ^ b_neg) & (i_b != '0);
                  neg_rem <= a_neg;
                  rem     <= '0;
                  cnt     <= CALC_LAST;
                  o_busy  <= 1'b1;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               rem <= no_borrow ? diff : rem_sh;
               quo <= {quo[XLEN-2:0], no_borrow};
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               o_result <= res_sel;
               o_busy   <= 1'b0;
               o_done   <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               o_done <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
